// File: rtl/alu_seq.sv
//==============================================================================
// Module   : alu_seq
// Brief    : Instruction beat generator / decoder driving the 8-bit ALU selects
//            and register-transfer strobes from a one-hot beat bus T[7:0].
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu_seq (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] IR,
    output logic [7:0] T,
    output logic       IMOV,
    output logic       IADD,
    output logic       ISUB,
    output logic       IMUL,
    output logic       IDIV,
    output logic       IOR,
    output logic       INOT,
    output logic       IAND,
    output logic       IXOR,
    output logic       ISHL,
    output logic       ISHR,
    output logic       EALU,
    output logic       LDA,
    output logic       LDB,
    output logic       WR,
    output logic       WDX,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       HLT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]  r_state;
    logic [3:0]  r_op;
    logic [7:0]  r_t;
    logic [10:0] r_isel;
    logic        r_ealu;
    logic        r_lda;
    logic        r_ldb;
    logic        r_wr;
    logic        r_wdx;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_hlt;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_op_nxt;
    logic [7:0]  w_t_nxt;
    logic        w_cur_muldiv;
    logic        w_cur_last;

    logic [10:0] w_isel_nxt;
    logic        w_ealu_nxt;
    logic        w_lda_nxt;
    logic        w_ldb_nxt;
    logic        w_wr_nxt;
    logic        w_wdx_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_hlt_nxt;

    logic        w_n_muldiv;
    logic        w_n_active;
    logic        w_n_illegal;
    logic        w_n_last;

    //--------------------------------------------------------------------------
    // State register: every output is a flop loaded from its next-value wire
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_t     <= 8'd0;
            r_isel  <= 11'd0;
            r_ealu  <= 1'b0;
            r_lda   <= 1'b0;
            r_ldb   <= 1'b0;
            r_wr    <= 1'b0;
            r_wdx   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hlt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_t     <= w_t_nxt;
            r_isel  <= w_isel_nxt;
            r_ealu  <= w_ealu_nxt;
            r_lda   <= w_lda_nxt;
            r_ldb   <= w_ldb_nxt;
            r_wr    <= w_wr_nxt;
            r_wdx   <= w_wdx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_hlt   <= w_hlt_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    assign w_cur_muldiv = (r_op == OP_MUL) || (r_op == OP_DIV);
    assign w_cur_last   = w_cur_muldiv ? r_t[7] : r_t[5];

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_t_nxt     = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_RUN;
                    w_op_nxt    = IR[7:4];
                    w_t_nxt     = 8'd1;
                end
            end
            S_RUN: begin
                // HLT shows T[0] and T[1], then parks with the beat bus cleared
                if ((r_op == OP_HLT) && r_t[1]) begin
                    w_state_nxt = S_HALT;
                end else if (w_cur_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_t_nxt = {r_t[6:0], 1'b0};
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output logic, decoded from the upcoming beat so that outputs are flops
    //--------------------------------------------------------------------------
    assign w_n_muldiv  = (w_op_nxt == OP_MUL) || (w_op_nxt == OP_DIV);
    assign w_n_active  = (w_op_nxt >= OP_MOV) && (w_op_nxt <= OP_SHR);
    assign w_n_illegal = (w_op_nxt >= 4'hC) && (w_op_nxt <= 4'hE);
    assign w_n_last    = w_n_muldiv ? w_t_nxt[7] : w_t_nxt[5];

    always_comb begin
        w_isel_nxt = 11'd0;
        w_ealu_nxt = 1'b0;
        w_lda_nxt  = 1'b0;
        w_ldb_nxt  = 1'b0;
        w_wr_nxt   = 1'b0;
        w_wdx_nxt  = 1'b0;
        w_busy_nxt = (w_t_nxt != 8'd0);
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_hlt_nxt  = (w_state_nxt == S_HALT);

        if ((w_state_nxt == S_RUN) && (w_op_nxt != OP_HLT)) begin
            w_done_nxt = w_n_last;
            w_err_nxt  = w_n_last && w_n_illegal;
        end

        if (w_n_active && (w_t_nxt[7:1] != 7'd0)) begin
            case (w_op_nxt)
                OP_MOV:  w_isel_nxt = 11'b100_0000_0000;
                OP_ADD:  w_isel_nxt = 11'b010_0000_0000;
                OP_SUB:  w_isel_nxt = 11'b001_0000_0000;
                OP_MUL:  w_isel_nxt = 11'b000_1000_0000;
                OP_DIV:  w_isel_nxt = 11'b000_0100_0000;
                OP_OR:   w_isel_nxt = 11'b000_0010_0000;
                OP_NOT:  w_isel_nxt = 11'b000_0001_0000;
                OP_AND:  w_isel_nxt = 11'b000_0000_1000;
                OP_XOR:  w_isel_nxt = 11'b000_0000_0100;
                OP_SHL:  w_isel_nxt = 11'b000_0000_0010;
                OP_SHR:  w_isel_nxt = 11'b000_0000_0001;
                default: w_isel_nxt = 11'd0;
            endcase
        end

        // MUL/DIV need an extra beat: low/quotient to AX at T[6], high/remainder to DX at T[7]
        if (w_n_active) begin
            w_lda_nxt = w_t_nxt[2];
            w_ldb_nxt = w_t_nxt[3];
            if (w_n_muldiv) begin
                w_ealu_nxt = w_t_nxt[6] | w_t_nxt[7];
                w_wr_nxt   = w_t_nxt[6];
                w_wdx_nxt  = w_t_nxt[7];
            end else begin
                w_ealu_nxt = w_t_nxt[5];
                w_wr_nxt   = w_t_nxt[5];
            end
        end
    end

    assign T    = r_t;
    assign IMOV = r_isel[10];
    assign IADD = r_isel[9];
    assign ISUB = r_isel[8];
    assign IMUL = r_isel[7];
    assign IDIV = r_isel[6];
    assign IOR  = r_isel[5];
    assign INOT = r_isel[4];
    assign IAND = r_isel[3];
    assign IXOR = r_isel[2];
    assign ISHL = r_isel[1];
    assign ISHR = r_isel[0];
    assign EALU = r_ealu;
    assign LDA  = r_lda;
    assign LDB  = r_ldb;
    assign WR   = r_wr;
    assign WDX  = r_wdx;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign ERR  = r_err;
    assign HLT  = r_hlt;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//==============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq; expected beats queued, monitor pops.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] IR = 8'h00;
    logic [7:0] T;
    logic       IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR;
    logic       EALU, LDA, LDB, WR, WDX, BUSY, DONE, ERR, HLT;

    alu_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .IR(IR), .T(T),
        .IMOV(IMOV), .IADD(IADD), .ISUB(ISUB), .IMUL(IMUL), .IDIV(IDIV),
        .IOR(IOR), .INOT(INOT), .IAND(IAND), .IXOR(IXOR), .ISHL(ISHL), .ISHR(ISHR),
        .EALU(EALU), .LDA(LDA), .LDB(LDB), .WR(WR), .WDX(WDX),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .HLT(HLT)
    );

    always #5 CLK = ~CLK;

    // {T, IMOV..ISHR, EALU, LDA, LDB, WR, WDX, BUSY, DONE, ERR, HLT}
    logic [27:0] w_act;
    assign w_act = {T, IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
                    EALU, LDA, LDB, WR, WDX, BUSY, DONE, ERR, HLT};

    int n_pass  = 0;
    int n_total = 0;
    logic [27:0] q_exp[$];

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for beat b of instruction ir
    function automatic logic [27:0] exp_beat(input logic [7:0] ir, input int b);
        logic [3:0]  op;
        logic        md, act, ill, done;
        logic [10:0] s;
        logic [7:0]  t;
        int          last;
        op   = ir[7:4];
        md   = (op == 4'h4) || (op == 4'h5);
        act  = (op >= 4'h1) && (op <= 4'hB);
        ill  = (op >= 4'hC) && (op <= 4'hE);
        last = md ? 7 : 5;
        t    = 8'd1 << b;
        s    = 11'd0;
        if (act && b >= 1) s = 11'd1 << (11 - int'(op));
        done = (op != 4'hF) && (b == last);
        return {t, s,
                act && (md ? (b >= 6) : (b == 5)),
                act && (b == 2),
                act && (b == 3),
                act && (md ? (b == 6) : (b == 5)),
                act && md && (b == 7),
                1'b1, done, done && ill, 1'b0};
    endfunction

    function automatic int nbeats(input logic [7:0] ir);
        return ((ir[7:4] == 4'h4) || (ir[7:4] == 4'h5)) ? 8 : 6;
    endfunction

    task automatic push(input logic [7:0] ir, input int n);
        for (int b = 0; b < n; b++) q_exp.push_back(exp_beat(ir, b));
    endtask

    // Single instruction, optional START pulse (with a different IR) mid-run
    task automatic run_instr(input logic [7:0] ir, input bit pulse);
        int n;
        n = nbeats(ir);
        push(ir, n);
        START = 1'b1;
        IR    = ir;
        @(posedge CLK); #1;
        START = 1'b0;
        IR    = ~ir;
        for (int c = 0; c < n; c++) begin
            if (pulse && c == 2) begin START = 1'b1; IR = 8'h40; end
            if (pulse && c == 3) START = 1'b0;
            @(posedge CLK); #1;
        end
        check("idle_after", w_act, 28'd0);
    endtask

    // Monitor: every active beat must match the next queued expectation
    always @(negedge CLK) begin
        if (!RST && BUSY) begin
            if (q_exp.size() == 0) check("unexpected_beat", w_act, 28'd0);
            else check("beat", w_act, q_exp.pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1 check("reset_state", w_act, 28'd0);
        RST = 1'b0;

        // Reset mid-MUL at T[3]
        push(8'h40, 4);
        START = 1'b1; IR = 8'h40;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #2;
        RST = 1'b1;
        #1 check("reset_async", w_act, 28'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        run_instr(8'h20, 1'b0);

        run_instr(8'h25, 1'b0);
        run_instr(8'h5A, 1'b0);
        run_instr(8'h40, 1'b0);
        run_instr(8'hC0, 1'b0);
        run_instr(8'h00, 1'b0);
        run_instr(8'h17, 1'b0);
        run_instr(8'hB3, 1'b0);
        run_instr(8'hE0, 1'b0);
        run_instr(8'h25, 1'b1);

        // Back-to-back OR with START held: one idle cycle between instructions
        START = 1'b1; IR = 8'h60;
        push(8'h60, 6); push(8'h60, 6); push(8'h60, 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (i == 2) START = 1'b0;
            repeat (6) @(posedge CLK);
            #1 check("b2b_gap", w_act, 28'd0);
        end

        // HLT: T[0], T[1], then halted; further STARTs ignored
        push(8'hF0, 2);
        START = 1'b1; IR = 8'hF0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check("halted", w_act, 28'd1);
        START = 1'b1; IR = 8'h20;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            check("halt_ignore", w_act, 28'd1);
        end
        START = 1'b0;
        RST = 1'b1;
        #1 check("halt_cleared", w_act, 28'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        run_instr(8'h90, 1'b0);

        repeat (3) @(posedge CLK);
        #1 check("queue_drained", 28'(q_exp.size()), 28'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Instruction beat generator and decoder directly upstream of the 8-bit ALU. Latches an 8-bit instruction, steps a one-hot beat bus T[7:0] and drives the ALU operation selects (IMOV…ISHR), EALU and register-transfer strobes for operand load and result write-back. It sequences the two-beat MUL/DIV result transfer (low/quotient to AX, high/remainder to DX) that the ALU's T-driven multiplier and divider rely on.

## Interface
- No parameters; data width fixed at 8 bits.
- CLK  in  1  system clock, rising-edge active
- RST  in  1  asynchronous, active-high reset
- START  in  1  instruction valid; sampled only in IDLE
- IR  in  8  instruction; IR[7:4] opcode, IR[3:0] ignored by this block
- T  out  8  one-hot beat bus, T[0]..T[7]; all-zero when not running
- IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR  out  1 each  ALU operation selects
- EALU  out  1  ALU output enable onto bus
- LDA, LDB  out  1  operand A / operand B register load strobes
- WR  out  1  write bus to destination (AX for MUL/DIV)
- WDX  out  1  write bus to DX
- BUSY  out  1  instruction in progress
- DONE  out  1  one-cycle pulse on last beat
- ERR  out  1  one-cycle pulse with DONE when opcode illegal
- HLT  out  1  halted; sticky until RST

## Operation
- Opcodes: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 OR, 7 NOT, 8 AND, 9 XOR, A SHL, B SHR, F HLT; C/D/E illegal.
- States: IDLE, RUN, HALTED. All outputs registered.
- IDLE: T=0, all strobes 0. START=1 at an edge → opcode latched, RUN, T=0000_0001.
- RUN: T shifts left one position per edge. Last beat is T[5] for short ops (NOP, MOV, ADD, SUB, OR, NOT, AND, XOR, SHL, SHR, illegal), T[7] for MUL/DIV. Edge after last beat → T=0, IDLE.
- Operation select: exactly one I* high from T[1] through last beat, for legal non-NOP opcodes; 0 at T[0] and in IDLE. At most one I* high ever.
- Beat actions (legal, non-NOP): T[2] LDA=1; T[3] LDB=1; T[4] execute, no strobes (DIV dividend/divisor latch on T[4] high, compute on its fall).
- Short ops: T[5] EALU=1, WR=1.
- MUL/DIV: T[5] no strobes; T[6] EALU=1, WR=1 (low product / quotient → AX); T[7] EALU=1, WDX=1 (high product / remainder → DX).
- NOP and illegal: full T[0]..T[5] sequence, no I*, EALU, LDA, LDB, WR, WDX; illegal asserts ERR with DONE.
- HLT: at T[1] enter HALTED; T=0, BUSY=0, HLT=1, all strobes 0; START ignored until RST. No DONE.
- BUSY=1 whenever T≠0. DONE=1 exactly during last beat.
- START while RUN or HALTED: ignored; IR changes after latch have no effect.

## Timing
- Reset (async, any time incl. mid-instruction): T=0, all I*, EALU, LDA, LDB, WR, WDX, BUSY, DONE, ERR, HLT = 0, state IDLE, latched opcode cleared. First START accepted at first rising edge after RST deasserts.
- Latency: START sampled at edge k → T[0] after edge k; short op T[5]/DONE after edge k+5; MUL/DIV T[7]/DONE after edge k+7; IDLE after next edge.
- Back-to-back: START held high → accepted at the IDLE edge following completion; one T=0 cycle between instructions (short op every 7 cycles, MUL/DIV every 9).
- EALU never high in the same cycle as LDA or LDB. WR and WDX never high together.
- T changes only on CLK edges; T is glitch-free one-hot or zero.

## Test plan
- Reset mid-op: IR=0x40 (MUL), START, assert RST at T[3] → all outputs 0 immediately; after release, IR=0x20 accepted, T[0] next edge.
- ADD: IR=0x25, START one cycle → T[0]..T[5] over 6 cycles, IADD=1 from T[1]–T[5], LDA at T[2], LDB at T[3], EALU+WR at T[5], DONE at T[5], then T=0.
- DIV: IR=0x5x, with A=0x64, B=0x07 on ALU → WR at T[6] carries 0x0E, WDX at T[7] carries 0x02; MUL with A=0x20, B=0x10 → 0x00 at T[6], 0x02 at T[7].
- Illegal 0xC0 → six beats, no I*/EALU/WR, ERR and DONE together at T[5]; NOP 0x00 → same, ERR=0.
- HLT 0xF0 → HLT=1 after T[1], T=0, subsequent STARTs with 0x20 ignored for 20 cycles; RST clears HLT.
- START held high with IR=0x60 → OR repeats every 7 cycles; START pulses during RUN are ignored (no restart, T sequence unbroken).
